// File: rtl/fifo_drain_pkg.sv
// Shared types and sizing helpers for the FIFO read-side drain stage.
package fifo_drain_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_state_e;

    localparam int BUF_DEPTH = 2;

    // Beat index width; a one-beat packet still needs a 1-bit counter.
    function automatic int beat_idx_width(input int pkt_len);
        return (pkt_len > 1) ? $clog2(pkt_len) : 1;
    endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// Two-entry in-order buffer absorbing the FIFO's registered read latency.
module drain_skid_buf
    import fifo_drain_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        occ,
    output logic              valid
);

    occ_state_e        state_r;
    logic [DATA_W-1:0] head_r;
    logic [DATA_W-1:0] tail_r;

    // Occupancy FSM with head/tail data movement; simultaneous push and pop keeps order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= EMPTY;
            head_r  <= '0;
            tail_r  <= '0;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (push) begin
                        head_r  <= push_data;
                        state_r <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_r <= push_data;
                    end else if (push) begin
                        tail_r  <= push_data;
                        state_r <= TWO;
                    end else if (pop) begin
                        state_r <= EMPTY;
                    end
                end
                TWO: begin
                    // A push without pop cannot happen here: the issue rule reserves a slot.
                    if (push && pop) begin
                        head_r <= tail_r;
                        tail_r <= push_data;
                    end else if (pop) begin
                        head_r  <= tail_r;
                        state_r <= ONE;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                end
            endcase
        end
    end

    assign head_data = head_r;
    assign occ       = state_r;
    assign valid     = (state_r != EMPTY);

endmodule

// File: rtl/fifo_stream_drain.sv
// Converts the FIFO enable/empty read port into a framed valid/ready stream.
module fifo_stream_drain
    import fifo_drain_pkg::*;
#(
    parameter int DATA_W  = 128,
    parameter int PKT_LEN = 16,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_enable,
    output logic              o_fifo_rden,
    input  logic [DATA_W-1:0] i_fifo_rddata,
    input  logic              i_fifo_empty,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_busy,
    output logic [CNT_W-1:0]  o_beat_total
);

    localparam int                IDX_W    = beat_idx_width(PKT_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PKT_LEN - 1);

    logic             inflight_r;
    logic [IDX_W-1:0] beat_idx_r;
    logic [CNT_W-1:0] beat_total_r;
    logic             valid_s;
    logic             pop_s;
    logic [1:0]       occ_s;
    logic [2:0]       level_s;

    drain_skid_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_r),
        .push_data (i_fifo_rddata),
        .pop       (pop_s),
        .head_data (o_data),
        .occ       (occ_s),
        .valid     (valid_s)
    );

    assign pop_s   = valid_s && i_ready;
    // Slots committed after this cycle: buffered plus returning data, less the beat leaving now.
    assign level_s = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};

    assign o_fifo_rden = !rst && i_enable && !i_fifo_empty && (level_s < 3'(BUF_DEPTH));

    // Track whether an accepted read returns data next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= o_fifo_rden && !i_fifo_empty;
        end
    end

    // Packet framing index and free-running accepted-beat total.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_idx_r   <= '0;
            beat_total_r <= '0;
        end else if (pop_s) begin
            beat_idx_r   <= (beat_idx_r == LAST_IDX) ? '0 : beat_idx_r + IDX_W'(1);
            beat_total_r <= beat_total_r + CNT_W'(1);
        end
    end

    assign o_valid      = valid_s;
    assign o_last       = valid_s && (beat_idx_r == LAST_IDX);
    assign o_busy       = valid_s || inflight_r;
    assign o_beat_total = beat_total_r;

endmodule

// File: tb/tb_fifo_stream_drain.sv
// Randomized bench for fifo_stream_drain against a queue-based FIFO and stream model.
module tb_fifo_stream_drain;

    localparam int DATA_W  = 128;
    localparam int PKT_LEN = 16;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_enable;
    logic              o_fifo_rden;
    logic [DATA_W-1:0] i_fifo_rddata;
    logic              i_fifo_empty;
    logic              o_valid;
    logic [DATA_W-1:0] o_data;
    logic              o_last;
    logic              i_ready;
    logic              o_busy;
    logic [CNT_W-1:0]  o_beat_total;

    always #5 clk = ~clk;

    fifo_stream_drain #(
        .DATA_W  (DATA_W),
        .PKT_LEN (PKT_LEN),
        .CNT_W   (CNT_W)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (i_enable),
        .o_fifo_rden   (o_fifo_rden),
        .i_fifo_rddata (i_fifo_rddata),
        .i_fifo_empty  (i_fifo_empty),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_last        (o_last),
        .i_ready       (i_ready),
        .o_busy        (o_busy),
        .o_beat_total  (o_beat_total)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] fifo_q[$];
    logic [DATA_W-1:0] exp_q[$];
    bit                infl = 1'b0;
    logic [DATA_W-1:0] pend_word = '0;
    int                beat_mod = 0;
    int                total = 0;
    int                cyc = 0;
    int                rden_cnt, acc_cnt, pop_cnt, run_len, max_run, last_cnt;
    int                first_rden_cyc, first_valid_cyc;
    bit                prev_rst = 1'b0;
    bit                prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data = '0;
    logic              prev_last = 1'b0;
    bit                want_first = 1'b0;
    logic [DATA_W-1:0] first_word = '0;

    task automatic check_val(input string tag, input logic [DATA_W-1:0] act,
                             input logic [DATA_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        rden_cnt = 0; acc_cnt = 0; pop_cnt = 0;
        run_len = 0; max_run = 0; last_cnt = 0;
        first_rden_cyc = -1; first_valid_cyc = -1;
    endtask

    // One clock: drive at negedge, check against the model, advance the model at posedge.
    task automatic step(input bit r, input bit rdy, input bit en, input bit fe);
        int                buffered;
        bit                exp_valid, pop_e, exp_rden, acc;
        logic [DATA_W-1:0] w;
        @(negedge clk);
        rst           = r;
        i_ready       = rdy;
        i_enable      = en;
        i_fifo_empty  = fe || (fifo_q.size() == 0);
        i_fifo_rddata = infl ? pend_word : {$urandom, $urandom, $urandom, $urandom};
        #1;
        buffered  = exp_q.size() - int'(infl);
        exp_valid = (buffered > 0);
        pop_e     = exp_valid && rdy;
        exp_rden  = !r && en && !i_fifo_empty && ((exp_q.size() - int'(pop_e)) < 2);

        check_val("rden",  DATA_W'(o_fifo_rden), DATA_W'(exp_rden));
        check_val("valid", DATA_W'(o_valid), DATA_W'(exp_valid));
        check_val("busy",  DATA_W'(o_busy), DATA_W'(exp_q.size() > 0));
        check_val("occ",   DATA_W'(u_dut.u_buf.occ), DATA_W'(buffered));
        check_val("total", DATA_W'(o_beat_total), DATA_W'(CNT_W'(total)));
        if (exp_valid) begin
            check_val("data", o_data, exp_q[0]);
            check_val("last", DATA_W'(o_last), DATA_W'(beat_mod == PKT_LEN - 1));
        end else begin
            check_val("last_idle", DATA_W'(o_last), DATA_W'(0));
        end
        if (prev_rst && !r) check_val("data_after_rst", o_data, DATA_W'(0));
        if (prev_stall && !r) begin
            check_val("stall_data", o_data, prev_data);
            check_val("stall_last", DATA_W'(o_last), DATA_W'(prev_last));
        end

        prev_stall = o_valid && !rdy && !r;
        prev_data  = o_data;
        prev_last  = o_last;
        prev_rst   = r;
        if (o_fifo_rden) rden_cnt++;
        if (o_fifo_rden && first_rden_cyc < 0) first_rden_cyc = cyc;
        if (o_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        run_len = o_valid ? run_len + 1 : 0;
        if (run_len > max_run) max_run = run_len;
        if (o_valid && rdy && o_last) last_cnt++;
        if (pop_e && want_first) begin
            first_word = o_data;
            want_first = 1'b0;
        end
        acc = o_fifo_rden && !i_fifo_empty;

        @(posedge clk);
        cyc++;
        w = '0;
        if (acc) begin
            w = fifo_q.pop_front();
            acc_cnt++;
        end
        if (r) begin
            exp_q.delete();
            infl     = 1'b0;
            beat_mod = 0;
            total    = 0;
        end else begin
            if (pop_e) begin
                void'(exp_q.pop_front());
                beat_mod = (beat_mod + 1) % PKT_LEN;
                total++;
                pop_cnt++;
            end
            if (acc) begin
                exp_q.push_back(w);
                pend_word = w;
            end
            infl = acc;
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        clear_stats();
    endtask

    // Run until FIFO and drain are empty, bounded by max_cyc.
    task automatic drain(input int max_cyc, input int rdy_pct, input bit toggle_empty);
        int c;
        bit fe;
        c  = 0;
        fe = 1'b0;
        while ((fifo_q.size() > 0 || exp_q.size() > 0) && c < max_cyc) begin
            step(1'b0, $urandom_range(99) < rdy_pct, 1'b1, toggle_empty && fe);
            fe = !fe;
            c++;
        end
        check_val("drain_done", DATA_W'(exp_q.size() == 0 && fifo_q.size() == 0), DATA_W'(1));
    endtask

    initial begin
        int c;
        logic [DATA_W-1:0] next_word;
        rst = 1'b1; i_enable = 1'b0; i_ready = 1'b0;
        i_fifo_empty = 1'b1; i_fifo_rddata = '0;
        clear_stats();
        do_reset();

        // Single beat
        fifo_q.push_back(DATA_W'(8'hA5));
        drain(20, 100, 1'b0);
        #1;
        check_val("single_rden_cycles", DATA_W'(rden_cnt), DATA_W'(1));
        check_val("single_latency", DATA_W'(first_valid_cyc - first_rden_cyc), DATA_W'(2));
        check_val("single_total", DATA_W'(o_beat_total), DATA_W'(1));

        // Streaming at full rate
        do_reset();
        for (int i = 0; i < 64; i++) fifo_q.push_back(DATA_W'(1000 + i));
        drain(200, 100, 1'b0);
        check_val("stream_valid_run", DATA_W'(max_run), DATA_W'(64));
        check_val("stream_last_cnt", DATA_W'(last_cnt), DATA_W'(4));

        // Random back-pressure
        do_reset();
        for (int i = 0; i < 200; i++) fifo_q.push_back({$urandom, $urandom, $urandom, $urandom});
        drain(3000, 55, 1'b0);
        check_val("bp_beats", DATA_W'(pop_cnt), DATA_W'(200));

        // Enable drop mid-packet
        do_reset();
        for (int i = 0; i < 30; i++) fifo_q.push_back(DATA_W'(3000 + i));
        c = 0;
        while (pop_cnt < 5 && c < 50) begin
            step(1'b0, 1'b1, 1'b1, 1'b0);
            c++;
        end
        check_val("en_reach_beat5", DATA_W'(pop_cnt), DATA_W'(5));
        repeat (8) step(1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        check_val("en_drop_busy", DATA_W'(o_busy), DATA_W'(0));
        check_val("en_drop_rden", DATA_W'(o_fifo_rden), DATA_W'(0));
        drain(200, 100, 1'b0);
        #1;
        check_val("en_total", DATA_W'(o_beat_total), DATA_W'(30));
        check_val("en_last_cnt", DATA_W'(last_cnt), DATA_W'(1));

        // Reset with buffered and in-flight data
        do_reset();
        for (int i = 0; i < 20; i++) fifo_q.push_back(DATA_W'(5000 + i));
        repeat (5) step(1'b0, 1'b0, 1'b1, 1'b0);
        check_val("rst_occ_full", DATA_W'(u_dut.u_buf.occ), DATA_W'(2));
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        next_word  = fifo_q[0];
        want_first = 1'b1;
        drain(200, 100, 1'b0);
        check_val("rst_next_word", first_word, next_word);

        // FIFO empty toggling every cycle
        do_reset();
        for (int i = 0; i < 40; i++) fifo_q.push_back(DATA_W'(7000 + i));
        drain(1000, 70, 1'b1);
        check_val("empty_acc_vs_beats", DATA_W'(acc_cnt), DATA_W'(pop_cnt));
        check_val("empty_beats", DATA_W'(pop_cnt), DATA_W'(40));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
